// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined unsigned approximate multiplier with per-beat accuracy mode,
// valid/ready handshakes on both sides and a completed-transfer counter.
module approx_mult_pipe #(
    parameter int unsigned W     = 8,
    parameter int unsigned K     = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       x,
    input  logic [W-1:0]       y,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     z,
    output logic [1:0]         z_mode,
    output logic [CNT_W-1:0]   txn_cnt
);

    localparam int unsigned PW = 2 * W;      // product width
    localparam int unsigned HW = 2 * W - K;  // retained-rows partial product width
    localparam int unsigned LW = W + K;      // low-rows partial product width

    // Stage 1 payload
    logic              s1_valid;
    logic [HW-1:0]     s1_h;
    logic [LW-1:0]     s1_c;
    logic [LW-1:0]     s1_l;
    logic [1:0]        s1_mode;

    logic              s2_load_c;
    logic              s1_load_c;
    logic [HW-1:0]     h_c;
    logic [LW-1:0]     c_c;
    logic [LW-1:0]     l_c;
    logic [PW-1:0]     hs_c;
    logic [PW-1:0]     z_c;

    // Backpressure chain: a stage may load when the stage after it is free or draining.
    assign s2_load_c = !out_valid || out_ready;
    assign s1_load_c = !s1_valid || s2_load_c;
    assign in_ready  = s1_load_c;

    // High rows kept exactly; the low rows are the part subject to truncation.
    always_comb begin
        h_c = HW'(y) * HW'(x[W-1:K]);
        l_c = LW'(y) * LW'(x[K-1:0]);
    end

    // Compensation term: every low-row bit that lands in the upper product half, summed exactly.
    always_comb begin
        c_c = '0;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < W; j++) begin
                if (i + j >= W) begin
                    c_c = c_c + (LW'(x[i] & y[j]) << (i + j));
                end
            end
        end
    end

    // Final add selects which low-row contribution joins the shifted high rows.
    always_comb begin
        hs_c = PW'(s1_h) << K;
        case (s1_mode)
            2'd1:    z_c = hs_c;
            2'd2:    z_c = hs_c + PW'(s1_c);
            default: z_c = hs_c + PW'(s1_l);
        endcase
    end

    // Stage 1 datapath registers; contents are qualified by s1_valid.
    always_ff @(posedge clk) begin
        if (in_valid && s1_load_c) begin
            s1_h    <= h_c;
            s1_c    <= c_c;
            s1_l    <= l_c;
            s1_mode <= mode;
        end
    end

    // Valids, output stage and counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            z         <= '0;
            z_mode    <= 2'd0;
            txn_cnt   <= '0;
        end else begin
            if (s1_load_c) begin
                s1_valid <= in_valid;
            end
            if (s2_load_c) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    z      <= z_c;
                    z_mode <= s1_mode;
                end
            end
            if (out_valid && out_ready) begin
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed bench for approx_mult_pipe: vector table, random stream with stall,
// back-to-back throughput, mid-flight reset and counter wrap on a narrow instance.
module tb_approx_mult_pipe;

    localparam int W = 8;
    localparam int K = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  x, y;
    logic [1:0]  mode, z_mode;
    logic [15:0] z;
    logic [31:0] txn_cnt;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [7:0]  w_x, w_y;
    logic [1:0]  w_mode, w_z_mode;
    logic [15:0] w_z;
    logic [3:0]  w_txn_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    approx_mult_pipe #(.W(8), .K(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .z_mode(z_mode), .txn_cnt(txn_cnt)
    );

    approx_mult_pipe #(.W(8), .K(4), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .x(w_x), .y(w_y), .mode(w_mode), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .z(w_z), .z_mode(w_z_mode), .txn_cnt(w_txn_cnt)
    );

    typedef struct {
        logic [7:0]  vx;
        logic [7:0]  vy;
        logic [1:0]  vmode;
        logic [15:0] exp_z;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Column-wise reference: builds the compensation term one product column at a time.
    function automatic logic [15:0] ref_z(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] m);
        logic [15:0] ex;
        logic [15:0] tr;
        logic [15:0] comp;
        int          cnt;
        ex   = 16'(a) * 16'(b);
        tr   = 16'(16'(a >> K) * 16'(b)) << K;
        comp = 16'd0;
        for (int col = W; col < 2 * W; col++) begin
            cnt = 0;
            for (int i = 0; i < K; i++) begin
                if (col - i < W) cnt += int'(a[i] & b[col - i]);
            end
            comp += 16'(cnt) << col;
        end
        case (m)
            2'd1:    return tr;
            2'd2:    return tr + comp;
            default: return ex;
        endcase
    endfunction

    vec_t        vecs[13];
    logic [17:0] q[$];
    logic [17:0] item;
    int          sent, got;
    logic        stalled_prev;
    logic [15:0] prev_z;
    logic [1:0]  prev_mode;
    logic        exp_ready;
    logic [3:0]  exp_cnt;
    logic [7:0]  bx, by;

    initial begin
        vecs[0]  = '{8'hFF, 8'hFF, 2'd0, 16'hFE01};
        vecs[1]  = '{8'hFF, 8'hFF, 2'd1, 16'hEF10};
        vecs[2]  = '{8'hFF, 8'hFF, 2'd2, 16'hFA10};
        vecs[3]  = '{8'hFF, 8'hFF, 2'd3, 16'hFE01};
        vecs[4]  = '{8'h0F, 8'hFF, 2'd1, 16'h0000};
        vecs[5]  = '{8'h0F, 8'hFF, 2'd2, 16'h0B00};
        vecs[6]  = '{8'h0F, 8'hFF, 2'd0, 16'h0EF1};
        vecs[7]  = '{8'h00, 8'hFF, 2'd2, 16'h0000};
        vecs[8]  = '{8'h01, 8'h80, 2'd2, 16'h0000};
        vecs[9]  = '{8'h02, 8'h80, 2'd2, 16'h0100};
        vecs[10] = '{8'hAB, 8'hCD, 2'd1, 16'h8020};
        vecs[11] = '{8'hAB, 8'hCD, 2'd2, 16'h8720};
        vecs[12] = '{8'hAB, 8'hCD, 2'd0, 16'h88EF};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; mode = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_x = '0; w_y = '0; w_mode = '0;
        next_cycle();
        do_reset();

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_z", 64'(z), 64'd0);
        chk("rst_z_mode", 64'(z_mode), 64'd0);
        chk("rst_txn_cnt", 64'(txn_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, each with its two-cycle latency checked
        for (int v = 0; v < 13; v++) begin
            next_cycle();
            in_valid = 1'b1; x = vecs[v].vx; y = vecs[v].vy; mode = vecs[v].vmode;
            #1;
            chk("vec_in_ready", 64'(in_ready), 64'd1);
            next_cycle();
            in_valid = 1'b0;
            chk("vec_latency_early", 64'(out_valid), 64'd0);
            next_cycle();
            chk("vec_out_valid", 64'(out_valid), 64'd1);
            chk("vec_z", 64'(z), 64'(vecs[v].exp_z));
            chk("vec_z_mode", 64'(z_mode), 64'(vecs[v].vmode));
        end

        // Random stream with a five-cycle output stall
        do_reset();
        sent = 0; got = 0; stalled_prev = 1'b0; prev_z = '0; prev_mode = '0;
        q.delete();
        for (int cyc = 0; cyc < 600 && got < 100; cyc++) begin
            next_cycle();
            out_ready = !(cyc >= 40 && cyc < 45);
            if (sent < 100) begin
                in_valid = (cyc >= 36 && cyc < 45) ? 1'b1 : ($urandom_range(0, 3) != 0);
                x = 8'($urandom); y = 8'($urandom); mode = 2'($urandom_range(0, 3));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled_prev) begin
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_z", 64'(z), 64'(prev_z));
                chk("stall_z_mode", 64'(z_mode), 64'(prev_mode));
            end
            exp_ready = (q.size() < 2) || out_ready;
            chk("stream_in_ready", 64'(in_ready), 64'(exp_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_spurious", 64'd1, 64'd0);
                end else begin
                    item = q.pop_front();
                    chk("stream_z", 64'(z), 64'(item[17:2]));
                    chk("stream_z_mode", 64'(z_mode), 64'(item[1:0]));
                end
                got++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_z = z; prev_mode = z_mode;
            if (in_valid && in_ready) begin
                q.push_back({ref_z(x, y, mode), mode});
                sent++;
            end
        end
        chk("stream_count", 64'(got), 64'd100);
        in_valid = 1'b0;
        next_cycle();
        chk("stream_txn_cnt", 64'(txn_cnt), 64'd100);

        // Back-to-back throughput
        do_reset();
        got = 0;
        for (int c = 0; c < 24; c++) begin
            next_cycle();
            out_ready = 1'b1;
            in_valid = (c < 20);
            x = 8'(c * 13 + 5); y = 8'(c * 29 + 1); mode = 2'(c);
            #1;
            if (c < 20) chk("b2b_in_ready", 64'(in_ready), 64'd1);
            if (out_valid) begin
                bx = 8'(got * 13 + 5); by = 8'(got * 29 + 1);
                chk("b2b_timing", 64'(c), 64'(got + 2));
                chk("b2b_z", 64'(z), 64'(ref_z(bx, by, 2'(got))));
                got++;
            end
        end
        chk("b2b_count", 64'(got), 64'd20);

        // Reset with two beats in flight under backpressure
        next_cycle();
        out_ready = 1'b0; in_valid = 1'b1; x = 8'h11; y = 8'h22; mode = 2'd0;
        next_cycle();
        x = 8'h33; y = 8'h44; mode = 2'd2;
        #1;
        chk("inflight_accept2", 64'(in_ready), 64'd1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        chk("inflight_full_valid", 64'(out_valid), 64'd1);
        chk("inflight_full_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_txn_cnt", 64'(txn_cnt), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            chk("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        // Counter wrap on the CNT_W=4 instance
        do_reset();
        got = 0; exp_cnt = 4'd0;
        for (int c = 0; c < 23; c++) begin
            next_cycle();
            w_out_ready = 1'b1;
            w_in_valid = (c < 17);
            w_x = 8'(c); w_y = 8'(c + 1); w_mode = 2'd0;
            #1;
            chk("wrap_cnt", 64'(w_txn_cnt), 64'(exp_cnt));
            if (w_out_valid && w_out_ready) begin
                got++;
                exp_cnt = 4'(exp_cnt + 4'd1);
            end
        end
        chk("wrap_count", 64'(got), 64'd17);
        chk("wrap_final", 64'(w_txn_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

Parametrised, pipelined unsigned approximate multiplier with run-time selectable accuracy mode and valid/ready handshakes on both sides. It generalises the fixed 8x8 truncated-row multipliers to any operand width W and truncation depth K. It is the drop-in arithmetic unit for streaming datapaths (filters, MAC arrays) where accuracy is traded for energy per transaction. Each transaction carries its own mode. A transaction counter supports throughput and error-rate bookkeeping.

## Interface
- W, default 8: operand width; product width is 2W.
- K, default 4: number of low x-bits (partial-product rows) subject to truncation; legal range 1..W-1.
- CNT_W, default 32: width of the completed-transaction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- x  in  W  unsigned multiplier.
- y  in  W  unsigned multiplicand.
- mode  in  2  accuracy mode for this beat: 0 exact, 1 row-truncated, 2 row-truncated with high-column compensation, 3 reserved (treated as exact).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- z  out  2W  product.
- z_mode  out  2  mode the result was computed with.
- txn_cnt  out  CNT_W  count of completed output transfers.

## Operation
- Let pp[i][j] = x[i] & y[j], with weight 2^(i+j).
- H = y * x[W-1:K], computed exactly (W+(W-K) bits wide).
- C = sum of pp[i][j] * 2^(i+j) over i < K and i+j >= W. Every retained bit is summed exactly; none are ORed.
- Mode 0 or 3: z = x*y, exact.
- Mode 1: z = H << K.
- Mode 2: z = (H << K) + C.
- In every mode z < 2^(2W), with no overflow or wrap.
- Results never exceed the exact product, and mode 2 is always >= mode 1.
- Pipeline stages:
  - Stage 1 registers H, C, the exact low-row sum (used by modes 0/3), and mode.
  - Stage 2 registers the final add into z/z_mode.
- Beats complete in order, one per cycle at full throughput, with no bubbles inserted.
- txn_cnt increments by 1 on each cycle where out_valid && out_ready. It wraps from 2^CNT_W-1 to 0.
- Reset behaviour:
  - Both stage valids are cleared, so out_valid=0 and any in-flight beats are discarded.
  - z=0, z_mode=0, txn_cnt=0.
  - in_ready=1 from the first cycle after reset deasserts.

## Timing
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+2 when there is no backpressure.
- Stage advance:
  - s2_load = !out_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load. This is a combinational path from out_ready and is permitted.
- Stall: while out_valid && !out_ready, z, z_mode and out_valid hold stable. Stage 1 holds its beat, and in_ready=0 once stage 1 is occupied.
- Capacity is 2 beats total. No beat is dropped or duplicated under any in_valid/out_ready pattern.
- Simultaneous events:
  - If an input transfer and an output transfer occur in the same cycle with both stages full, the pipeline shifts by one and stays full.
  - The counter increments in that cycle.
- If in_valid is high while in_ready is low, x/y/mode are not sampled.
- Reset mid-stream: if rst_n=0 is sampled during any cycle, the following cycle shows out_valid=0 and txn_cnt=0 regardless of out_ready.

## Test plan
- W=8, K=4, x=0xFF, y=0xFF, out_ready=1. Expected z: mode0 -> 0xFE01; mode1 -> 0xEF10; mode2 -> 0xFA10; mode3 -> 0xFE01. Each appears 2 cycles after acceptance with the matching z_mode.
- x=0x0F, y=0xFF: mode1 -> z=0x0000; mode2 -> z=0x0B00; mode0 -> z=0x0EF1.
- Stream 100 random beats with random modes, with out_ready held low for 5 cycles mid-stream. Required:
  - outputs in order and matching the reference model;
  - in_ready=0 while both stages are full;
  - z stable during the stall;
  - txn_cnt=100 at the end.
- Back-to-back throughput: in_valid=1 and out_ready=1 for 20 cycles. Required: 20 results on consecutive cycles starting at cycle 2, and in_ready never low.
- Reset asserted with 2 beats in flight and out_ready=0. Required: next cycle out_valid=0, txn_cnt=0, in_ready=1; no stale beat ever emerges.
- CNT_W=4: complete 17 transfers. Required: txn_cnt wraps to 0 after the 16th transfer and reads 1 after the 17th.
